// File: rtl/multi_q_measurement.sv
// Multi-channel pulse-charge measurement: per-channel pulse counting with watchdog, round-robin result output.
// Define Q_SAT_EN to clamp out-of-range charge results instead of truncating them modulo 2**BUS_WIDTH.
module multi_q_measurement #(
  parameter int N_CH          = 4,
  parameter int BUS_WIDTH     = 10,
  parameter int CNT_WIDTH     = 6,
  parameter int WTD_BUS_WIDTH = 2,
  parameter int Q_PER_PULSE   = 30
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [N_CH-1:0]                             q_serialized,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  out_ch,
  output logic [BUS_WIDTH-1:0]                        out_q
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int QW   = $clog2(Q_PER_PULSE + 1);
  localparam int PW   = CNT_WIDTH + QW;

  localparam logic [CNT_WIDTH-1:0]     CNT_MAX = '1;
  localparam logic [WTD_BUS_WIDTH-1:0] WTD_MAX = '1;
  localparam logic [BUS_WIDTH-1:0]     Q_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COUNTING = 2'd2,
    DONE     = 2'd3
  } ch_state_e;

  ch_state_e                st  [N_CH];
  logic [CNT_WIDTH-1:0]     cnt [N_CH];
  logic [WTD_BUS_WIDTH-1:0] wtd [N_CH];
  logic [BUS_WIDTH-1:0]     res [N_CH];

  logic [N_CH-1:0] sync1, sync2, edge_q, rise;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant_idx;
  logic            grant_found;
  logic            xfer;

  function automatic logic [BUS_WIDTH-1:0] reduce_q(input logic [CNT_WIDTH-1:0] c);
    logic [PW-1:0] prod;
    prod = PW'(c) * PW'(Q_PER_PULSE);
`ifdef Q_SAT_EN
    if ((PW + BUS_WIDTH)'(prod) > (PW + BUS_WIDTH)'(Q_MAX)) return Q_MAX;
`endif
    return BUS_WIDTH'(prod);
  endfunction

  // Two-flop synchroniser; edge_q holds the previous synchronised level so a
  // level held high yields a single rise pulse.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      edge_q <= '0;
    end else begin
      sync1  <= q_serialized;
      sync2  <= sync1;
      edge_q <= sync2;
    end
  end

  assign rise = sync2 & ~edge_q;
  assign xfer = out_valid & out_ready;

  // Round-robin pick among DONE channels, skipping the one currently being presented.
  always_comb begin
    int idx;
    // NOTE: defaults first so every path assigns these and no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(rr_ptr) + k) % N_CH;
      if (!grant_found && st[idx] == DONE && !(out_valid && out_ch == CH_W'(idx))) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      // NOTE: per-channel result storage is cleared too, so no stale charge survives an abort or reset.
      if (rst || !start) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
        wtd[i] <= WTD_MAX;
        res[i] <= '0;
      end else begin
        case (st[i])
          IDLE: st[i] <= ARMED;
          ARMED: begin
            if (rise[i]) begin
              st[i]  <= COUNTING;
              cnt[i] <= CNT_WIDTH'(1);
              wtd[i] <= WTD_MAX;
            end
          end
          COUNTING: begin
            if (rise[i]) begin
              if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_WIDTH'(1);
              wtd[i] <= WTD_MAX;
            end else if (wtd[i] == '0) begin
              st[i]  <= DONE;
              res[i] <= reduce_q(cnt[i]);
            end else begin
              wtd[i] <= wtd[i] - WTD_BUS_WIDTH'(1);
            end
          end
          DONE: begin
            // Edges arriving here are ignored until the result is taken.
            if (xfer && out_ch == CH_W'(i)) begin
              st[i]  <= ARMED;
              cnt[i] <= '0;
              wtd[i] <= WTD_MAX;
            end
          end
          default: st[i] <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_q     <= '0;
      rr_ptr    <= '0;
    end else if (!start) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_q     <= '0;
    end else if (!out_valid || out_ready) begin
      out_valid <= grant_found;
      if (grant_found) begin
        out_ch <= grant_idx;
        out_q  <= res[grant_idx];
        rr_ptr <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
      end
    end
  end

endmodule

// File: doc/multi_q_measurement.md
MULTI_Q_MEASUREMENT -- requirements
Module: multi_q_measurement

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of independent pulse channels (1..16).
REQ-002 The block SHALL have parameter BUS_WIDTH, default 10: width of the charge result.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 6: width of each per-channel pulse counter.
REQ-004 The block SHALL have parameter WTD_BUS_WIDTH, default 2: width of each per-channel watchdog.
REQ-005 The block SHALL have parameter Q_PER_PULSE, default 30: charge weight of one pulse.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-008 The block SHALL have port start, input, 1 bit: measurement enable; low acts as a synchronous abort.
REQ-009 The block SHALL have port q_serialized, input, N_CH bits: asynchronous pulse trains, one bit per channel.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result; transfer occurs when out_valid and out_ready are both high.
REQ-012 The block SHALL have port out_ch, output, clog2(N_CH) bits (minimum 1): source channel of the presented result.
REQ-013 The block SHALL have port out_q, output, BUS_WIDTH bits: measured charge.

Function
REQ-014 Each q_serialized bit SHALL pass through a 2-flop synchroniser plus one edge register; a rising edge SHALL be detected exactly 3 clk cycles after the input rises, at most once per input pulse.
REQ-015 Each channel SHALL implement the states IDLE, ARMED, COUNTING and DONE.
REQ-016 Per-channel transitions SHALL be: IDLE->ARMED while start=1; ARMED->COUNTING on a detected edge (count=1, wtd=2**WTD_BUS_WIDTH-1); COUNTING->DONE; DONE->ARMED on transfer of that channel's result.
REQ-017 In COUNTING, a detected edge SHALL increment count and reload wtd; otherwise wtd SHALL decrement. When wtd==0 and no edge is detected, the channel SHALL enter DONE, which is 2**WTD_BUS_WIDTH cycles after the last edge.
REQ-018 An edge that coincides with wtd==0 SHALL win: the pulse is counted and wtd is reloaded.
REQ-019 count SHALL saturate at 2**CNT_WIDTH-1 and SHALL never wrap.
REQ-020 On entry to DONE, the channel SHALL latch result = count*Q_PER_PULSE, computed at full width (CNT_WIDTH + clog2(Q_PER_PULSE+1) bits) and reduced to BUS_WIDTH per REQ-030.
REQ-021 Edges detected while a channel is in DONE SHALL be dropped; they SHALL NOT be counted and SHALL NOT restart the watchdog.
REQ-022 The output arbiter SHALL grant the DONE channels round-robin, starting at the index after the last granted channel; after reset the search starts at channel 0.
REQ-023 out_valid SHALL assert on the cycle after a channel enters DONE when the output is idle, and otherwise on the cycle after the previous transfer.
REQ-024 While out_valid=1 and out_ready=0, out_ch and out_q SHALL remain stable.
REQ-025 Back-to-back transfers SHALL be supported: one result per cycle when several channels are DONE and out_ready is held high.
REQ-026 start=0 SHALL, on the next edge, force all channels to IDLE, clear all counts and pending results, and drop out_valid; any in-flight result is discarded.

Reset
REQ-027 With rst=1 at a clk edge, all channels SHALL go to IDLE, with count=0, wtd=2**WTD_BUS_WIDTH-1, synchronisers and edge registers at 0, and the round-robin pointer at 0.
REQ-028 During and after reset, outputs SHALL be out_valid=0, out_ch=0 and out_q=0; rst SHALL take priority over start and over all other inputs.
REQ-029 An assertion of rst mid-measurement SHALL discard all counts and results, and no result from before the reset SHALL ever appear on the output.

Configuration
REQ-030 Macro Q_SAT_EN SHALL select the result reduction: when defined, a result exceeding 2**BUS_WIDTH-1 clamps to 2**BUS_WIDTH-1; when undefined, the result is truncated to its low BUS_WIDTH bits (modulo).

Verification
REQ-031 Defaults, out_ready=1, 5 pulses on ch0 spaced 6 cycles apart -> exactly one transfer with out_ch=0 and out_q=150, with out_valid rising 5 cycles after the last detected edge.
REQ-032 ch1 and ch2 each receive 2 pulses aligned to the same cycles -> two consecutive transfers: (ch1, 60) then (ch2, 60).
REQ-033 40 pulses on ch3 -> count=40 and out_q=1023 with Q_SAT_EN defined, or out_q=176 without it; 70 pulses -> count saturates at 63.
REQ-034 ch0 result pending with out_ready=0 for 10 cycles while 3 more pulses arrive on ch0 -> out_q stays at its value and stable throughout; the 3 pulses are dropped; after acceptance the channel re-arms.
REQ-035 start dropped mid-count on ch2, or rst pulsed for 1 cycle mid-count -> out_valid=0 on the next cycle, no output for that measurement, and a fresh 1-pulse measurement then yields 30.
